// File: rtl/aurora_clk_seq_pkg.sv
// Shared types for the Aurora clock sequencer: state encodings, control bundle and helpers.
package aurora_clk_seq_pkg;

  localparam int unsigned STATE_W     = 3;
  localparam int unsigned LOCK_LOSS_W = 16;

  typedef enum logic [STATE_W-1:0] {
    S_RESET     = 3'd0,
    S_WAIT_PLL  = 3'd1,
    S_CLR       = 3'd2,
    S_WAIT_MMCM = 3'd3,
    S_STABLE    = 3'd4,
    S_HOLD      = 3'd5,
    S_RUN       = 3'd6,
    S_FAULT     = 3'd7
  } seq_state_e;

  typedef struct packed {
    logic tx_clk_clr;
    logic mmcm_clk_locked;
    logic aurora_reset;
    logic clk_ready;
    logic fault;
  } seq_ctl_t;

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Control outputs implied by being in a given state.
  function automatic seq_ctl_t state_ctl(input seq_state_e s);
    seq_ctl_t c;
    c.tx_clk_clr      = 1'b1;
    c.mmcm_clk_locked = 1'b0;
    c.aurora_reset    = 1'b1;
    c.clk_ready       = 1'b0;
    c.fault           = 1'b0;
    case (s)
      S_WAIT_MMCM, S_STABLE, S_HOLD: begin
        c.tx_clk_clr      = 1'b0;
        c.mmcm_clk_locked = 1'b1;
      end
      S_RUN: begin
        c.tx_clk_clr      = 1'b0;
        c.mmcm_clk_locked = 1'b1;
        c.aurora_reset    = 1'b0;
        c.clk_ready       = 1'b1;
      end
      S_FAULT: c.fault = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/aurora_clk_sequencer_lock_sync.sv
// Two-flop synchronizer for an asynchronous lock indication, with a synchronous reset value.
module lock_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  (* ASYNC_REG = "TRUE" *) logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= {2{RESET_VAL}};
    else        sync_q <= {sync_q[0], async_in};
  end

  assign sync_out = sync_q[1];

endmodule

// File: rtl/aurora_clk_sequencer.sv
// Aurora clock bring-up sequencer: PLL wait, TX clock clear, MMCM release/qualify, core reset release.
// Optional LOCK_LOSS_COUNT counter enabled by defining AURORA_CLK_SEQ_LOSS_COUNT_EN.
module aurora_clk_sequencer
  import aurora_clk_seq_pkg::*;
#(
  parameter int unsigned CLR_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned RESET_HOLD    = 128,
  parameter int unsigned MAX_RETRIES   = 7,
  parameter int unsigned RETRY_W       = 3
) (
  input  logic                   INIT_CLK,
  input  logic                   INIT_RST_N,
  input  logic                   GT_PLL_LOCKED,
  input  logic                   MMCM_NOT_LOCKED,
  output logic                   TX_CLK_CLR,
  output logic                   MMCM_CLK_LOCKED,
  output logic                   AURORA_RESET,
  output logic                   CLK_READY,
  output logic                   FAULT,
  output logic [RETRY_W-1:0]     RETRY_COUNT,
  output logic [STATE_W-1:0]     STATE,
  output logic [LOCK_LOSS_W-1:0] LOCK_LOSS_COUNT
);

  localparam int unsigned TIMER_MAX = max_of(max_of(CLR_CYCLES, LOCK_TIMEOUT),
                                             max_of(STABLE_CYCLES, RESET_HOLD));
  localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);

  localparam logic [TIMER_W-1:0] CLR_LAST    = TIMER_W'(CLR_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(RESET_HOLD - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  logic pll_s;
  logic mmcm_unlock_s;
  logic mmcm_s;
  logic lock_drop;

  seq_state_e         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               retry_req;
  seq_ctl_t           ctl_q;

  lock_sync #(.RESET_VAL(1'b0)) u_pll_sync (
    .clk      (INIT_CLK),
    .rst_n    (INIT_RST_N),
    .async_in (GT_PLL_LOCKED),
    .sync_out (pll_s)
  );

  lock_sync #(.RESET_VAL(1'b1)) u_mmcm_sync (
    .clk      (INIT_CLK),
    .rst_n    (INIT_RST_N),
    .async_in (MMCM_NOT_LOCKED),
    .sync_out (mmcm_unlock_s)
  );

  assign mmcm_s    = ~mmcm_unlock_s;
  assign lock_drop = ~pll_s | ~mmcm_s;

  always_ff @(posedge INIT_CLK) begin
    if (!INIT_RST_N) begin
      state_q <= S_RESET;
      timer_q <= '0;
      retry_q <= '0;
      ctl_q   <= state_ctl(S_RESET);
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      ctl_q   <= state_ctl(state_d);
    end
  end

  // Next state; any failure funnels into a single retry decision below.
  always_comb begin
    state_d   = state_q;
    timer_d   = '0;
    retry_d   = retry_q;
    retry_req = 1'b0;
    case (state_q)
      S_RESET:    state_d = S_WAIT_PLL;
      S_WAIT_PLL: if (pll_s) state_d = S_CLR;
      S_CLR: begin
        if (!pll_s)                    retry_req = 1'b1;
        else if (timer_q == CLR_LAST)  state_d   = S_WAIT_MMCM;
      end
      S_WAIT_MMCM: begin
        if (!pll_s)                        retry_req = 1'b1;
        else if (mmcm_s)                   state_d   = S_STABLE;
        else if (timer_q == TIMEOUT_LAST)  retry_req = 1'b1;
      end
      S_STABLE: begin
        if (lock_drop)                    retry_req = 1'b1;
        else if (timer_q == STABLE_LAST)  state_d   = S_HOLD;
      end
      S_HOLD: begin
        if (lock_drop)                  retry_req = 1'b1;
        else if (timer_q == HOLD_LAST)  state_d   = S_RUN;
      end
      S_RUN:   if (lock_drop) retry_req = 1'b1;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_RESET;
    endcase

    if (retry_req) begin
      if (retry_q == RETRY_LIMIT) begin
        state_d = S_FAULT;
      end else begin
        retry_d = retry_q + RETRY_W'(1);
        state_d = S_WAIT_PLL;
      end
    end

    if (state_d == S_RUN && state_q != S_RUN) retry_d = '0;
    if (state_d == state_q) timer_d = timer_q + TIMER_W'(1);
  end

  assign TX_CLK_CLR      = ctl_q.tx_clk_clr;
  assign MMCM_CLK_LOCKED = ctl_q.mmcm_clk_locked;
  assign AURORA_RESET    = ctl_q.aurora_reset;
  assign CLK_READY       = ctl_q.clk_ready;
  assign FAULT           = ctl_q.fault;
  assign RETRY_COUNT     = retry_q;
  assign STATE           = state_q;

`ifdef AURORA_CLK_SEQ_LOSS_COUNT_EN
  logic [LOCK_LOSS_W-1:0] loss_q;

  // Counts RUN exits caused by a lock drop, saturating.
  always_ff @(posedge INIT_CLK) begin
    if (!INIT_RST_N)                                      loss_q <= '0;
    else if (state_q == S_RUN && lock_drop && loss_q != '1) loss_q <= loss_q + LOCK_LOSS_W'(1);
  end

  assign LOCK_LOSS_COUNT = loss_q;
`else
  assign LOCK_LOSS_COUNT = '0;
`endif

endmodule

// File: tb/tb_aurora_clk_sequencer.sv
// Bench for aurora_clk_sequencer: directed bring-up/fault scenarios plus random lock activity,
// checked every cycle against a rule-level reference model.
module tb_aurora_clk_sequencer;

  localparam int unsigned CLR_CYCLES    = 4;
  localparam int unsigned LOCK_TIMEOUT  = 32;
  localparam int unsigned STABLE_CYCLES = 8;
  localparam int unsigned RESET_HOLD    = 4;
  localparam int unsigned MAX_RETRIES   = 2;
  localparam int unsigned RETRY_W       = 3;
`ifdef AURORA_CLK_SEQ_LOSS_COUNT_EN
  localparam int LOSS_EN = 1;
`else
  localparam int LOSS_EN = 0;
`endif

  logic        INIT_CLK = 1'b0;
  logic        INIT_RST_N;
  logic        GT_PLL_LOCKED;
  logic        MMCM_NOT_LOCKED;
  logic        TX_CLK_CLR;
  logic        MMCM_CLK_LOCKED;
  logic        AURORA_RESET;
  logic        CLK_READY;
  logic        FAULT;
  logic [2:0]  RETRY_COUNT;
  logic [2:0]  STATE;
  logic [15:0] LOCK_LOSS_COUNT;

  int n_checks = 0;
  int n_errors = 0;

  aurora_clk_sequencer #(
    .CLR_CYCLES    (CLR_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .RESET_HOLD    (RESET_HOLD),
    .MAX_RETRIES   (MAX_RETRIES),
    .RETRY_W       (RETRY_W)
  ) dut (
    .INIT_CLK        (INIT_CLK),
    .INIT_RST_N      (INIT_RST_N),
    .GT_PLL_LOCKED   (GT_PLL_LOCKED),
    .MMCM_NOT_LOCKED (MMCM_NOT_LOCKED),
    .TX_CLK_CLR      (TX_CLK_CLR),
    .MMCM_CLK_LOCKED (MMCM_CLK_LOCKED),
    .AURORA_RESET    (AURORA_RESET),
    .CLK_READY       (CLK_READY),
    .FAULT           (FAULT),
    .RETRY_COUNT     (RETRY_COUNT),
    .STATE           (STATE),
    .LOCK_LOSS_COUNT (LOCK_LOSS_COUNT)
  );

  always #5 INIT_CLK = ~INIT_CLK;

  // ---------------- reference model ----------------
  // Phases: 0 reset, 1 wait pll, 2 clear, 3 wait mmcm, 4 stable, 5 hold, 6 run, 7 fault.
  int m_phase, m_dwell, m_retry, m_loss, m_next;
  bit m_valid = 1'b0;
  bit m_fail, m_pll, m_mmcm;
  bit pll_pipe[$];
  bit mmcm_pipe[$];

  // Outputs {clr, mmcm_locked, aurora_reset, ready, fault} for each phase.
  function automatic logic [4:0] phase_outputs(input int p);
    case (p)
      3, 4, 5: return 5'b01100;
      6:       return 5'b01010;
      7:       return 5'b10101;
      default: return 5'b10100;
    endcase
  endfunction

  function automatic int phase_len(input int p);
    case (p)
      2:       return int'(CLR_CYCLES);
      3:       return int'(LOCK_TIMEOUT);
      4:       return int'(STABLE_CYCLES);
      5:       return int'(RESET_HOLD);
      default: return 0;
    endcase
  endfunction

  always @(posedge INIT_CLK) begin
    if (!INIT_RST_N) begin
      m_valid = 1'b1;
      m_phase = 0; m_dwell = 0; m_retry = 0; m_loss = 0;
      pll_pipe.delete();  pll_pipe.push_back(1'b0);  pll_pipe.push_back(1'b0);
      mmcm_pipe.delete(); mmcm_pipe.push_back(1'b0); mmcm_pipe.push_back(1'b0);
    end else if (m_valid) begin
      // Locks as seen by the sequencer lag the pins by two samples.
      m_pll  = pll_pipe.pop_front();
      m_mmcm = mmcm_pipe.pop_front();
      pll_pipe.push_back(GT_PLL_LOCKED);
      mmcm_pipe.push_back(!MMCM_NOT_LOCKED);
      m_next = m_phase;
      m_fail = 1'b0;
      case (m_phase)
        0: m_next = 1;
        1: if (m_pll) m_next = 2;
        2: if (!m_pll) m_fail = 1'b1;
           else if (m_dwell + 1 == phase_len(2)) m_next = 3;
        3: if (!m_pll) m_fail = 1'b1;
           else if (m_mmcm) m_next = 4;
           else if (m_dwell + 1 == phase_len(3)) m_fail = 1'b1;
        4, 5: if (!m_pll || !m_mmcm) m_fail = 1'b1;
              else if (m_dwell + 1 == phase_len(m_phase)) m_next = m_phase + 1;
        6: if (!m_pll || !m_mmcm) begin
             m_fail = 1'b1;
             if (LOSS_EN != 0 && m_loss < 65535) m_loss = m_loss + 1;
           end
        default: ;
      endcase
      if (m_fail) begin
        if (m_retry == int'(MAX_RETRIES)) m_next = 7;
        else begin m_retry = m_retry + 1; m_next = 1; end
      end
      if (m_next == 6 && m_phase != 6) m_retry = 0;
      m_dwell = (m_next == m_phase) ? m_dwell + 1 : 0;
      m_phase = m_next;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge INIT_CLK) begin
    logic [28:0] act, exp;
    if (m_valid) begin
      act = {STATE, TX_CLK_CLR, MMCM_CLK_LOCKED, AURORA_RESET, CLK_READY, FAULT,
             RETRY_COUNT, LOCK_LOSS_COUNT, 2'b00};
      exp = {3'(m_phase), phase_outputs(m_phase), 3'(m_retry), 16'(m_loss), 2'b00};
      n_checks++;
      if (act !== exp) begin
        n_errors++;
        $display("FAIL model_compare t=%0t actual=%h required=%h", $time, act, exp);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge INIT_CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic do_reset();
    INIT_RST_N = 1'b0;
    tick(1);
    INIT_RST_N = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (STATE !== s && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, 32'(STATE), 32'(s));
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_state"}, 32'(STATE), 32'd0);
    chk({name, "_outs"}, 32'({TX_CLK_CLR, MMCM_CLK_LOCKED, AURORA_RESET, CLK_READY, FAULT}),
        32'(5'b10100));
    chk({name, "_retry"}, 32'(RETRY_COUNT), 32'd0);
    chk({name, "_loss"}, 32'(LOCK_LOSS_COUNT), 32'd0);
  endtask

  initial begin
    int wm_cycles, n;
    INIT_RST_N = 1'b0;
    GT_PLL_LOCKED = 1'b0;
    MMCM_NOT_LOCKED = 1'b1;

    // Nominal bring-up, edge numbers relative to the reset edge E0.
    do_reset();
    chk_reset_outputs("reset");
    tick(10);
    GT_PLL_LOCKED = 1'b1;
    tick(2);  chk("nom_still_wait_pll", 32'(STATE), 32'd1);
    tick(1);  chk("nom_clr_entry", 32'(STATE), 32'd2);
    tick(3);  chk("nom_clr_last", 32'({STATE, TX_CLK_CLR}), 32'({3'd2, 1'b1}));
    tick(1);  chk("nom_mmcm_release", 32'({STATE, TX_CLK_CLR, MMCM_CLK_LOCKED}),
                  32'({3'd3, 1'b0, 1'b1}));
    tick(5);
    MMCM_NOT_LOCKED = 1'b0;
    tick(14); chk("nom_hold_last", 32'({STATE, CLK_READY, AURORA_RESET}), 32'({3'd5, 1'b0, 1'b1}));
    tick(1);  chk("nom_run", 32'({STATE, CLK_READY, AURORA_RESET, RETRY_COUNT}),
                  32'({3'd6, 1'b1, 1'b0, 3'd0}));

    // Loss of PLL lock while running.
    GT_PLL_LOCKED = 1'b0;
    tick(3);
    chk("loss_outs", 32'({STATE, CLK_READY, AURORA_RESET, RETRY_COUNT}),
        32'({3'd1, 1'b0, 1'b1, 3'd1}));
    chk("loss_count", 32'(LOCK_LOSS_COUNT), 32'(LOSS_EN));
    GT_PLL_LOCKED = 1'b1;
    wait_state(3'd6, 100, "loss_recover");
    chk("loss_recover_retry", 32'(RETRY_COUNT), 32'd0);

    // One-cycle MMCM glitch at stable count 5.
    do_reset();
    wait_state(3'd4, 100, "glitch_reach_stable");
    tick(3);
    MMCM_NOT_LOCKED = 1'b1;
    tick(1);
    MMCM_NOT_LOCKED = 1'b0;
    wait_state(3'd1, 10, "glitch_retry");
    chk("glitch_outs", 32'({RETRY_COUNT, MMCM_CLK_LOCKED}), 32'({3'd1, 1'b0}));

    // MMCM never locks: three timeout windows, then sticky fault.
    MMCM_NOT_LOCKED = 1'b1;
    do_reset();
    wm_cycles = 0;
    n = 0;
    while (FAULT !== 1'b1 && n < 400) begin
      tick(1);
      n++;
      if (STATE == 3'd3) wm_cycles++;
    end
    chk("timeout_windows", 32'(wm_cycles), 32'(3 * LOCK_TIMEOUT));
    chk("timeout_fault", 32'({STATE, FAULT, RETRY_COUNT, TX_CLK_CLR, MMCM_CLK_LOCKED}),
        32'({3'd7, 1'b1, 3'd2, 1'b1, 1'b0}));
    MMCM_NOT_LOCKED = 1'b0;
    tick(20);
    chk("fault_sticky", 32'({STATE, FAULT}), 32'({3'd7, 1'b1}));
    do_reset();
    chk_reset_outputs("fault_reset");

    // Reset asserted during HOLD aborts and resequences.
    wait_state(3'd5, 100, "reach_hold");
    do_reset();
    chk_reset_outputs("hold_reset");
    wait_state(3'd6, 100, "hold_reset_rerun");

    // Random lock activity, judged entirely by the model.
    for (int i = 0; i < 20000; i++) begin
      if (GT_PLL_LOCKED) begin
        if ($urandom_range(0, 299) == 0) GT_PLL_LOCKED = 1'b0;
      end else if ($urandom_range(0, 9) == 0) GT_PLL_LOCKED = 1'b1;
      if (!MMCM_NOT_LOCKED) begin
        if ($urandom_range(0, 199) == 0) MMCM_NOT_LOCKED = 1'b1;
      end else if ($urandom_range(0, 7) == 0) MMCM_NOT_LOCKED = 1'b0;
      INIT_RST_N = ($urandom_range(0, 2999) != 0);
      tick(1);
    end
    INIT_RST_N = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
